tdc_phase_decoder: RTL

//  TDC digital front end feeding the ADPLL controller's tdc_word input.
//  - Samples the DCO ripple-edge counter and the 16-cell delay-line snapshot once per reference clock.
//  - Bubble-corrects and decodes the snapshot into a fractional DCO phase.
//  - Normalises that phase by a periodically re-estimated DCO period (in delay cells).
//  - Outputs the wrap-aware phase increment per reference cycle as integer + fraction.

---
 rtl/tdc_phase_decoder_if.sv | 26 ++
 rtl/tdc_phase_decoder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_phase_decoder_if.sv
// rtl/tdc_phase_decoder_if.sv - sample inputs and phase-increment outputs of the TDC front end
interface tdc_phase_decoder_if #(
  parameter int CNT_W = 7,
  parameter int PH_W  = 16,
  parameter int INT_W = 12,
  parameter int FRA_W = 8
);
  logic             en;
  logic [CNT_W-1:0] counter_in;
  logic [PH_W-1:0]  phase_in;
  logic [INT_W-1:0] tdc_word;
  logic [FRA_W-1:0] tdc_frac;
  logic             tdc_valid;
  logic             gain_valid;
  logic             bubble_err;

  modport master (
    output en, counter_in, phase_in,
    input  tdc_word, tdc_frac, tdc_valid, gain_valid, bubble_err
  );

  modport slave (
    input  en, counter_in, phase_in,
    output tdc_word, tdc_frac, tdc_valid, gain_valid, bubble_err
  );
endinterface

// File: rtl/tdc_phase_decoder.sv
// rtl/tdc_phase_decoder.sv - delay-line decode, period-normalised fractional phase, wrap-aware increment
module tdc_phase_decoder #(
  parameter int CNT_W    = 7,
  parameter int PH_W     = 16,
  parameter int INT_W    = 12,
  parameter int FRA_W    = 8,
  parameter int AVG_LOG2 = 4
) (
  input logic                clk,
  input logic                rst,
  tdc_phase_decoder_if.slave bus
);
  localparam int EP_W  = $clog2(PH_W + 1);
  localparam int SUM_W = EP_W + AVG_LOG2;
  localparam int REM_W = SUM_W + 1;
  localparam int NS_W  = AVG_LOG2 + 1;
  localparam int DC_W  = (FRA_W > 1) ? $clog2(FRA_W) : 1;
  localparam int P_W   = CNT_W + FRA_W;
  localparam int PR_W  = EP_W + FRA_W;

  localparam logic [NS_W-1:0]  NS_LAST  = NS_W'(2 ** AVG_LOG2 - 1);
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(2 ** AVG_LOG2);
  localparam logic [DC_W-1:0]  DC_LAST  = DC_W'(FRA_W - 1);

  typedef enum logic [1:0] {ST_ACC, ST_DIV, ST_LOAD} state_t;

  // S1 sample registers
  logic [CNT_W-1:0] cnt1_q;
  logic [PH_W-1:0]  ph1_q;
  logic             v1_q;
  // S2 decoded registers
  logic [CNT_W-1:0] cnt2_q;
  logic [FRA_W-1:0] frac2_q;
  logic             v2_q;
  logic             bub2_q;
  // S3 output registers
  logic [INT_W-1:0] word3_q;
  logic [FRA_W-1:0] frac3_q;
  logic             valid3_q;
  logic             first_q;
  logic [P_W-1:0]   pprev_q;
  // gain estimator
  state_t           state_q, state_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [NS_W-1:0]  ns_q, ns_d;
  logic [REM_W-1:0] rem_q, rem_d, rem_sh;
  logic [FRA_W-1:0] quo_q, quo_d;
  logic [DC_W-1:0]  dcnt_q, dcnt_d;
  logic [FRA_W-1:0] gain_q, gain_d;
  logic             gain_valid_q, gain_valid_d;

  // decode signals
  logic [PH_W+1:0]  ph_ext;
  logic [PH_W-1:0]  bc;
  logic             edge_found, per_found, smp_take, bubble_now;
  logic [EP_W-1:0]  edge_idx, per_idx, edge_pos, per_smp;
  logic [PR_W-1:0]  prod;
  logic [FRA_W-1:0] frac_sat;
  logic [P_W-1:0]   p_cur, p_diff;

  // Line ends replicate their edge cell so the end cells vote with themselves
  assign ph_ext = {ph1_q[PH_W-1], ph1_q, ph1_q[0]};

  // Majority-of-three bubble correction over each cell and its neighbours
  always_comb begin
    bc = '0;
    for (int i = 0; i < PH_W; i++) begin
      bc[i] = (ph_ext[i] & ph_ext[i+1]) | (ph_ext[i] & ph_ext[i+2]) | (ph_ext[i+1] & ph_ext[i+2]);
    end
  end

  // First 1->0 transition gives the phase edge; the next 0->1 after it closes a half period
  always_comb begin
    edge_found = 1'b0;
    edge_idx   = '0;
    per_found  = 1'b0;
    per_idx    = '0;
    for (int i = 0; i < PH_W - 1; i++) begin
      if (!edge_found && bc[i] && !bc[i+1]) begin
        edge_found = 1'b1;
        edge_idx   = EP_W'(i);
      end
    end
    for (int j = 1; j < PH_W - 1; j++) begin
      if (edge_found && !per_found && (EP_W'(j) > edge_idx) && !bc[j] && bc[j+1]) begin
        per_found = 1'b1;
        per_idx   = EP_W'(j);
      end
    end
  end

  assign edge_pos   = edge_found ? (edge_idx + EP_W'(1)) : EP_W'(PH_W);
  assign per_smp    = (per_idx - edge_idx) << 1;
  assign smp_take   = v1_q & edge_found & per_found;
  assign bubble_now = (bc != ph1_q);
  assign prod       = {{FRA_W{1'b0}}, edge_pos} * {{EP_W{1'b0}}, gain_q};
  assign frac_sat   = !gain_valid_q ? '0 : ((|prod[PR_W-1:FRA_W]) ? '1 : prod[FRA_W-1:0]);
  assign p_cur      = {cnt2_q, frac2_q};
  assign p_diff     = p_cur - pprev_q;
  assign rem_sh     = {rem_q[REM_W-2:0], 1'b0};

  // S1: capture the ripple count and delay-line snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt1_q <= '0;
      ph1_q  <= '0;
      v1_q   <= 1'b0;
    end else if (bus.en) begin
      cnt1_q <= bus.counter_in;
      ph1_q  <= bus.phase_in;
      v1_q   <= 1'b1;
    end
  end

  // S2: register count, normalised fraction and the bubble flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt2_q  <= '0;
      frac2_q <= '0;
      v2_q    <= 1'b0;
      bub2_q  <= 1'b0;
    end else if (bus.en) begin
      cnt2_q  <= cnt1_q;
      frac2_q <= frac_sat;
      v2_q    <= v1_q;
      bub2_q  <= v1_q & bubble_now;
    end
  end

  // S3: modular difference against the previous phase; the first sample only seeds it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word3_q  <= '0;
      frac3_q  <= '0;
      valid3_q <= 1'b0;
      first_q  <= 1'b1;
      pprev_q  <= '0;
    end else if (bus.en && v2_q) begin
      pprev_q <= p_cur;
      first_q <= 1'b0;
      if (!first_q) begin
        valid3_q <= 1'b1;
        word3_q  <= INT_W'(p_diff[P_W-1:FRA_W]);
        frac3_q  <= p_diff[FRA_W-1:0];
      end
    end
  end

  // Gain estimator: accumulate half-period samples, divide, then publish the new gain
  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    ns_d         = ns_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    dcnt_d       = dcnt_q;
    gain_d       = gain_q;
    gain_valid_d = gain_valid_q;
    unique case (state_q)
      ST_ACC: begin
        if (smp_take) begin
          sum_d = sum_q + SUM_W'(per_smp);
          ns_d  = ns_q + NS_W'(1);
          if (ns_q == NS_LAST) begin
            state_d = ST_DIV;
            rem_d   = REM_INIT;
            quo_d   = '0;
            dcnt_d  = '0;
          end
        end
      end
      ST_DIV: begin
        if (rem_sh >= {1'b0, sum_q}) begin
          rem_d = rem_sh - {1'b0, sum_q};
          quo_d = {quo_q[FRA_W-2:0], 1'b1};
        end else begin
          rem_d = rem_sh;
          quo_d = {quo_q[FRA_W-2:0], 1'b0};
        end
        dcnt_d = dcnt_q + DC_W'(1);
        if (dcnt_q == DC_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        gain_d       = quo_q;
        gain_valid_d = 1'b1;
        sum_d        = '0;
        ns_d         = '0;
        state_d      = ST_ACC;
      end
      default: state_d = ST_ACC;
    endcase
  end

  // Gain estimator state; a reset mid-divide drops the partial quotient
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_ACC;
      sum_q        <= '0;
      ns_q         <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      dcnt_q       <= '0;
      gain_q       <= '0;
      gain_valid_q <= 1'b0;
    end else if (bus.en) begin
      state_q      <= state_d;
      sum_q        <= sum_d;
      ns_q         <= ns_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      dcnt_q       <= dcnt_d;
      gain_q       <= gain_d;
      gain_valid_q <= gain_valid_d;
    end
  end

  assign bus.tdc_word   = word3_q;
  assign bus.tdc_frac   = frac3_q;
  assign bus.tdc_valid  = valid3_q;
  assign bus.gain_valid = gain_valid_q;
  assign bus.bubble_err = bub2_q;
endmodule
